// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: sequential word fetches, in-order prefetch FIFO, redirect with stale-response discard.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_prefetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req_valid,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_req_ready,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   output logic        o_inst_valid,
   output logic [31:0] o_inst_data,
   output logic [31:0] o_inst_pc,
   input  logic        i_inst_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_redirects,
   output logic [31:0] o_perf_dropped
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {StRun, StDrain} FetchState;

   FetchState     r_state;
   FetchState     w_stateNext;
   logic [31:0]   r_fetchPc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] w_discardNext;
   logic [31:0]   r_fifoData [FIFO_DEPTH];
   logic [31:0]   r_fifoPc   [FIFO_DEPTH];
   logic [PW-1:0] r_fifoWr;
   logic [PW-1:0] r_fifoRd;
   logic [CW-1:0] r_fifoCount;
   logic [31:0]   r_pcq [FIFO_DEPTH];
   logic [PW-1:0] r_pcqWr;
   logic [PW-1:0] r_pcqRd;

   logic [CW:0]   w_inflight;
   logic          w_reqValid;
   logic          w_reqFire;
   logic          w_rspAcc;
   logic          w_drop;
   logic          w_push;
   logic          w_instValid;
   logic          w_pop;
   logic [31:0]   w_redirectPc;

   // Credits cover both buffered words and words still in flight, so the FIFO can never overflow.
   assign w_inflight   = {1'b0, r_fifoCount} + {1'b0, r_outstanding};
   assign w_reqValid   = !i_reset && !i_redirect_valid && (w_inflight < DEPTH_W);
   assign w_reqFire    = w_reqValid && i_imem_req_ready;
   assign w_rspAcc     = i_imem_rsp_valid && (r_outstanding != '0);
   assign w_drop       = w_rspAcc && (i_redirect_valid || (r_discard != '0));
   assign w_push       = w_rspAcc && !w_drop;
   assign w_instValid  = (r_fifoCount != '0);
   assign w_pop        = w_instValid && i_inst_ready;
   assign w_redirectPc = i_redirect_pc & ~32'd3;

   assign o_imem_req_valid = w_reqValid;
   assign o_imem_req_addr  = r_fetchPc;
   assign o_inst_valid     = w_instValid;
   assign o_inst_data      = w_instValid ? r_fifoData[r_fifoRd] : '0;
   assign o_inst_pc        = w_instValid ? r_fifoPc[r_fifoRd]   : '0;

   always_comb begin
      w_discardNext = r_discard;
      w_stateNext   = r_state;
      if (i_redirect_valid) begin
         w_discardNext = r_outstanding - CW'(w_rspAcc);
      end else if (w_rspAcc && (r_discard != '0)) begin
         w_discardNext = r_discard - CW'(1);
      end
      case (r_state)
         StRun:   if (i_redirect_valid && (w_discardNext != '0)) w_stateNext = StDrain;
         StDrain: if (w_discardNext == '0) w_stateNext = StRun;
         default: w_stateNext = StRun;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= StRun;
         r_fetchPc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_fifoWr      <= '0;
         r_fifoRd      <= '0;
         r_fifoCount   <= '0;
         r_pcqWr       <= '0;
         r_pcqRd       <= '0;
      end else begin
         r_state       <= w_stateNext;
         r_discard     <= w_discardNext;
         r_outstanding <= r_outstanding + CW'(w_reqFire) - CW'(w_rspAcc);
         if (i_redirect_valid) begin
            r_fetchPc   <= w_redirectPc;
            r_fifoWr    <= '0;
            r_fifoRd    <= '0;
            r_fifoCount <= '0;
            r_pcqWr     <= '0;
            r_pcqRd     <= '0;
         end else begin
            if (w_reqFire) begin
               r_fetchPc <= r_fetchPc + 32'd4;
               r_pcqWr   <= r_pcqWr + PW'(1);
            end
            if (w_push) begin
               r_pcqRd  <= r_pcqRd + PW'(1);
               r_fifoWr <= r_fifoWr + PW'(1);
            end
            if (w_pop) r_fifoRd <= r_fifoRd + PW'(1);
            r_fifoCount <= r_fifoCount + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // Storage needs no reset; validity comes from the pointers and counts above.
   always_ff @(posedge i_clk) begin
      if (w_reqFire) r_pcq[r_pcqWr] <= r_fetchPc;
      if (w_push) begin
         r_fifoData[r_fifoWr] <= i_imem_rsp_data;
         r_fifoPc[r_fifoWr]   <= r_pcq[r_pcqRd];
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perfFetched;
   logic [31:0] r_perfRedirects;
   logic [31:0] r_perfDropped;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_perfFetched   <= '0;
         r_perfRedirects <= '0;
         r_perfDropped   <= '0;
      end else begin
         r_perfFetched   <= r_perfFetched + 32'(w_pop);
         r_perfRedirects <= r_perfRedirects + 32'(i_redirect_valid);
         r_perfDropped   <= r_perfDropped + 32'(w_drop);
      end
   end

   assign o_perf_fetched   = r_perfFetched;
   assign o_perf_redirects = r_perfRedirects;
   assign o_perf_dropped   = r_perfDropped;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: in-order memory model plus expected-instruction scoreboard.
module tb_fetch_prefetch_unit;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        o_imem_req_valid;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_req_ready;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        o_inst_valid;
   logic [31:0] o_inst_data;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] o_perf_fetched;
   logic [31:0] o_perf_redirects;
   logic [31:0] o_perf_dropped;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int memLat = 1;
   int epoch = 0;
   int accepted = 0;
   int benchPops = 0;
   int benchRedirects = 0;
   int benchDropped = 0;
   logic readyToggle = 1'b0;
   logic consumerReady = 1'b1;
   logic injectStale = 1'b0;
   logic [31:0] nextAddr = 32'h0;

   logic [31:0] memAddrQ [$];
   int          memDueQ [$];
   int          memEpochQ [$];
   logic [63:0] expQ [$];
   logic [31:0] popLog [$];

   logic        lastReqValid;
   logic [31:0] lastReqAddr;
   logic        lastInstValid;
   logic [31:0] lastInstPc;
   logic        lastPop;
   logic        lastRsp;

   always #5 i_clk = ~i_clk;

   fetch_prefetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
      .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
      .i_imem_req_ready(i_imem_req_ready),
      .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
      .o_inst_valid(o_inst_valid), .o_inst_data(o_inst_data), .o_inst_pc(o_inst_pc),
      .i_inst_ready(i_inst_ready)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_perf_fetched(o_perf_fetched), .o_perf_redirects(o_perf_redirects),
      .o_perf_dropped(o_perf_dropped)
`endif
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, want);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, sample #1 later, update memory model and scoreboard.
   task automatic applyStimulus(input logic doReset, input logic doRedirect, input logic [31:0] rpc);
      logic rspGiven;
      int   rspEpoch;
      logic [63:0] want;
      @(negedge i_clk);
      i_reset          = doReset;
      i_redirect_valid = doRedirect;
      i_redirect_pc    = rpc;
      i_inst_ready     = consumerReady;
      i_imem_req_ready = readyToggle ? ((cyc % 2) == 0) : 1'b1;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = '0;
      rspGiven = 1'b0;
      rspEpoch = epoch;
      if (doReset) begin
         memAddrQ.delete(); memDueQ.delete(); memEpochQ.delete();
      end else if (injectStale) begin
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_data  = 32'hBAD0_BAD0;
         injectStale      = 1'b0;
      end else if (memDueQ.size() != 0 && memDueQ[0] <= cyc) begin
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_data  = memWord(memAddrQ[0]);
         rspEpoch = memEpochQ[0];
         rspGiven = 1'b1;
         memAddrQ.delete(0); memDueQ.delete(0); memEpochQ.delete(0);
      end
      #1;
      lastReqValid  = o_imem_req_valid;
      lastReqAddr   = o_imem_req_addr;
      lastInstValid = o_inst_valid;
      lastInstPc    = o_inst_pc;
      lastPop       = 1'b0;
      lastRsp       = rspGiven;
      if (doReset) begin
         checkOutput("req_valid_in_reset", 64'(o_imem_req_valid), 64'd0);
         expQ.delete(); popLog.delete();
         nextAddr = 32'h0;
         epoch++;
         benchPops = 0; benchRedirects = 0; benchDropped = 0;
      end else begin
         if (o_inst_valid && i_inst_ready) begin
            lastPop = 1'b1;
            benchPops++;
            popLog.push_back(o_inst_pc);
            if (expQ.size() == 0) checkOutput("inst_underflow", 64'(expQ.size()), 64'd1);
            else begin
               want = expQ.pop_front();
               checkOutput("inst_pc_data", {o_inst_pc, o_inst_data}, want);
            end
         end
         if (doRedirect) begin
            checkOutput("req_valid_at_redirect", 64'(o_imem_req_valid), 64'd0);
            expQ.delete(); popLog.delete();
            nextAddr = rpc & ~32'd3;
            epoch++;
            benchRedirects++;
         end else if (o_imem_req_valid && i_imem_req_ready) begin
            checkOutput("req_addr", 64'(o_imem_req_addr), 64'(nextAddr));
            memAddrQ.push_back(o_imem_req_addr);
            memDueQ.push_back(cyc + memLat);
            memEpochQ.push_back(epoch);
            expQ.push_back({nextAddr, memWord(nextAddr)});
            nextAddr = nextAddr + 32'd4;
            accepted++;
         end
         if (rspGiven && rspEpoch != epoch) benchDropped++;
      end
      cyc++;
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0);
   endtask

   task automatic checkPopAt(input string tag, input int idx, input logic [31:0] want);
      if (popLog.size() > idx) checkOutput(tag, 64'(popLog[idx]), 64'(want));
      else checkOutput({tag, "_missing"}, 64'(popLog.size()), 64'(idx + 1));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int startPops;
      i_reset = 1'b1; i_redirect_valid = 1'b0; i_redirect_pc = '0;
      i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0; i_inst_ready = 1'b0;

      // Reset release, 1-cycle memory, always-ready consumer.
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("inst_valid_in_reset", 64'(lastInstValid), 64'd0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("first_req_valid", 64'(lastReqValid), 64'd1);
      checkOutput("first_req_addr", 64'(lastReqAddr), 64'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("inst_valid_cycle1", 64'(lastInstValid), 64'd0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("inst_valid_cycle2", 64'(lastInstValid), 64'd1);
      checkOutput("inst_pc_cycle2", 64'(lastInstPc), 64'h0);
      startPops = benchPops;
      runCycles(20);
      checkOutput("throughput", 64'(benchPops - startPops), 64'd20);

      // Stalled consumer: exactly FIFO_DEPTH requests, head holds PC 0.
      applyStimulus(1'b1, 1'b0, 32'h0);
      consumerReady = 1'b0;
      accepted = 0;
      runCycles(10);
      checkOutput("stall_accepted", 64'(accepted), 64'd4);
      checkOutput("stall_req_valid", 64'(lastReqValid), 64'd0);
      checkOutput("stall_inst_valid", 64'(lastInstValid), 64'd1);
      checkOutput("stall_inst_pc", 64'(lastInstPc), 64'h0);
      consumerReady = 1'b1;
      runCycles(10);

      // Three requests in flight when the redirect lands; all must be dropped.
      memLat = 4;
      applyStimulus(1'b1, 1'b0, 32'h0);
      runCycles(3);
      applyStimulus(1'b0, 1'b1, 32'h0000_0100);
      checkOutput("redir3_rsp_at_T", 64'(lastRsp), 64'd0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("redir3_next_req", 64'(lastReqAddr), 64'h100);
      runCycles(20);
      checkPopAt("redir3_first_pc", 0, 32'h0000_0100);
      checkPopAt("redir3_second_pc", 1, 32'h0000_0104);

      // Redirect in the same cycle as a response and a pop.
      memLat = 3;
      applyStimulus(1'b1, 1'b0, 32'h0);
      runCycles(3);
      for (int t = 0; t < 30; t++) begin
         @(posedge i_clk); #1;
         if (o_inst_valid && memDueQ.size() != 0 && memDueQ[0] <= cyc) break;
         applyStimulus(1'b0, 1'b0, 32'h0);
      end
      applyStimulus(1'b0, 1'b1, 32'h0000_2000);
      checkOutput("redir4_pop_at_T", 64'(lastPop), 64'd1);
      checkOutput("redir4_rsp_at_T", 64'(lastRsp), 64'd1);
      runCycles(20);
      checkPopAt("redir4_first_pc", 0, 32'h0000_2000);

      // Address wrap with a toggling request-ready; low address bits ignored.
      memLat = 2;
      readyToggle = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFB);
      runCycles(24);
      checkPopAt("wrap_pc0", 0, 32'hFFFF_FFF8);
      checkPopAt("wrap_pc1", 1, 32'hFFFF_FFFC);
      checkPopAt("wrap_pc2", 2, 32'h0000_0000);
      checkPopAt("wrap_pc3", 3, 32'h0000_0004);
      readyToggle = 1'b0;

      // Back-to-back redirects: the later one wins.
      applyStimulus(1'b0, 1'b1, 32'h0000_0300);
      applyStimulus(1'b0, 1'b1, 32'h0000_0400);
      runCycles(15);
      checkPopAt("b2b_first_pc", 0, 32'h0000_0400);

      // Reset mid-stream, then a stale response while nothing is outstanding.
      memLat = 3;
      runCycles(6);
      applyStimulus(1'b1, 1'b0, 32'h0);
      injectStale = 1'b1;
      runCycles(15);
      checkPopAt("stale_first_pc", 0, 32'h0000_0000);
      checkPopAt("stale_second_pc", 1, 32'h0000_0004);

`ifdef FETCH_PERF_CNT_EN
      applyStimulus(1'b0, 1'b1, 32'h0000_0800);
      runCycles(8);
      applyStimulus(1'b0, 1'b1, 32'h0000_0900);
      runCycles(12);
      @(posedge i_clk); #1;
      checkOutput("perf_fetched", 64'(o_perf_fetched), 64'(benchPops));
      checkOutput("perf_redirects", 64'(o_perf_redirects), 64'(benchRedirects));
      checkOutput("perf_dropped", 64'(o_perf_dropped), 64'(benchDropped));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
